// File: rtl/pipeline_hazard_unit.sv
// ID-stage hazard controller for the 5-stage MIPS pipeline.
// Detects load-use and jr-source hazards and sequences PC redirects for
// j/jal and jr (resolved in ID) and beq (resolved in EX).
// Outputs are Mealy: a function of the registered state and the current inputs.
// Optional build macro: HAZARD_STATS_EN adds the saturating StallCount output.
module pipeline_hazard_unit #(
   parameter int unsigned REG_W   = 5,
   parameter int unsigned COUNT_W = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             IDJump,
   input  logic             IDJr,
   input  logic             IDBranch,
   input  logic [REG_W-1:0] IDRs,
   input  logic [REG_W-1:0] IDRt,
   input  logic             IDUseRt,
   input  logic             EXMemRead,
   input  logic             EXRegWrite,
   input  logic [REG_W-1:0] EXWriteReg,
   input  logic             EXBranchTaken,
   output logic             PCWrite,
   output logic             IFWrite,
   output logic             Bubble,
   output logic [1:0]       AddrSel
`ifdef HAZARD_STATS_EN
   ,
   output logic [COUNT_W-1:0] StallCount
`endif
);

   typedef enum logic [2:0] {
      NOHAZ,
      JUMP,
      BRANCH_WAIT,
      BRANCH_TAKEN,
      JR_WAIT
   } state_e;

   typedef enum logic [1:0] {
      SEL_PC4    = 2'b00,
      SEL_JUMP   = 2'b01,
      SEL_BRANCH = 2'b10,
      SEL_JR     = 2'b11
   } addr_sel_e;

   state_e state_q, state_d;
   logic   ex_dest_valid;
   logic   loaduse;
   logic   jrhaz;

   // Hazard detection against the instruction currently in EX; r0 never hazards.
   always_comb begin
      ex_dest_valid = (EXWriteReg != '0);
      loaduse = EXMemRead & ex_dest_valid &
                ((EXWriteReg == IDRs) | (IDUseRt & (EXWriteReg == IDRt)));
      jrhaz   = IDJr & EXRegWrite & ex_dest_valid & (EXWriteReg == IDRs);
   end

   // Next-state and Mealy output decode.
   always_comb begin
      state_d = state_q;
      PCWrite = 1'b1;
      IFWrite = 1'b1;
      Bubble  = 1'b0;
      AddrSel = SEL_PC4;
      unique case (state_q)
         NOHAZ: begin
            if (loaduse) begin
               PCWrite = 1'b0;
               IFWrite = 1'b0;
               Bubble  = 1'b1;
            end else if (jrhaz) begin
               PCWrite = 1'b0;
               IFWrite = 1'b0;
               Bubble  = 1'b1;
               state_d = JR_WAIT;
            end else if (IDJump) begin
               AddrSel = SEL_JUMP;
               IFWrite = 1'b0;
               state_d = JUMP;
            end else if (IDJr) begin
               AddrSel = SEL_JR;
               IFWrite = 1'b0;
               state_d = JUMP;
            end else if (IDBranch) begin
               PCWrite = 1'b0;
               IFWrite = 1'b0;
               state_d = BRANCH_WAIT;
            end
         end
         // Squash the instruction fetched behind the redirect.
         JUMP: begin
            Bubble  = 1'b1;
            state_d = NOHAZ;
         end
         BRANCH_WAIT: begin
            Bubble = 1'b1;
            if (EXBranchTaken) begin
               AddrSel = SEL_BRANCH;
               IFWrite = 1'b0;
               state_d = BRANCH_TAKEN;
            end else begin
               state_d = NOHAZ;
            end
         end
         BRANCH_TAKEN: begin
            Bubble  = 1'b1;
            state_d = NOHAZ;
         end
         // Producer is now in MEM and forwarded to ID, so the jr target is valid.
         JR_WAIT: begin
            AddrSel = SEL_JR;
            IFWrite = 1'b0;
            state_d = JUMP;
         end
         default: state_d = NOHAZ;
      endcase
   end

   // State register; synchronous reset wins over every transition.
   always_ff @(posedge CLK) begin
      if (Reset) state_q <= NOHAZ;
      else       state_q <= state_d;
   end

`ifdef HAZARD_STATS_EN
   logic [COUNT_W-1:0] stall_count_q, stall_count_d;

   // Count cycles lost to bubbles or PC holds, saturating at all-ones.
   always_comb begin
      stall_count_d = stall_count_q;
      if ((Bubble | ~PCWrite) && (stall_count_q != '1))
         stall_count_d = stall_count_q + COUNT_W'(1);
   end

   // Stall counter register.
   always_ff @(posedge CLK) begin
      if (Reset) stall_count_q <= '0;
      else       stall_count_q <= stall_count_d;
   end

   assign StallCount = stall_count_q;
`else
   // COUNT_W only sizes the statistics counter; keep it referenced when compiled out.
   if (COUNT_W == 0) begin : g_no_stats
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: expected outputs are queued when
// stimulus is driven and popped for comparison mid-cycle.
module tb_pipeline_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       jump, jr, br, use_rt, memrd, regwr, taken;
   logic [4:0] rs, rt, wr;
   logic       pc_write, if_write, bubble;
   logic [1:0] addr_sel;
   logic [15:0] exp_cnt;
`ifdef HAZARD_STATS_EN
   logic [15:0] stall_count;
   logic [15:0] cnt_before;
`endif

   typedef struct packed {
      logic       pcw;
      logic       ifw;
      logic       bub;
      logic [1:0] addr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipeline_hazard_unit #(.REG_W(5), .COUNT_W(16)) dut (
      .CLK(clk),
      .Reset(rst),
      .IDJump(jump),
      .IDJr(jr),
      .IDBranch(br),
      .IDRs(rs),
      .IDRt(rt),
      .IDUseRt(use_rt),
      .EXMemRead(memrd),
      .EXRegWrite(regwr),
      .EXWriteReg(wr),
      .EXBranchTaken(taken),
      .PCWrite(pc_write),
      .IFWrite(if_write),
      .Bubble(bubble),
      .AddrSel(addr_sel)
`ifdef HAZARD_STATS_EN
      ,
      .StallCount(stall_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      jump = 0; jr = 0; br = 0; use_rt = 0; memrd = 0; regwr = 0; taken = 0;
      rs = 0; rt = 0; wr = 0;
   endtask

   // One clock with current inputs; outputs checked at the negative edge.
   task automatic step(input string tag, input logic pcw, input logic ifw,
                       input logic bub, input logic [1:0] addr);
      exp_t e;
      exp_t got;
      e = '{pcw: pcw, ifw: ifw, bub: bub, addr: addr};
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      check({tag, ".PCWrite"}, 32'(pc_write), 32'(got.pcw));
      check({tag, ".IFWrite"}, 32'(if_write), 32'(got.ifw));
      check({tag, ".Bubble"},  32'(bubble),   32'(got.bub));
      check({tag, ".AddrSel"}, 32'(addr_sel), 32'(got.addr));
`ifdef HAZARD_STATS_EN
      check({tag, ".StallCount"}, 32'(stall_count), 32'(exp_cnt));
`endif
      @(posedge clk);
      if (rst) exp_cnt = '0;
      else if ((got.bub || !got.pcw) && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
      #1;
   endtask

   // Unchecked clock, used only while Reset is asserted.
   task automatic tick();
      @(negedge clk);
      @(posedge clk);
      if (rst) exp_cnt = '0;
      #1;
   endtask

   initial begin
      exp_cnt = '0;
      idle();
      rst = 1;
      @(posedge clk); #1;
      tick();
      step("reset_hold", 1, 1, 0, 2'b00);
      rst = 0;
      step("idle", 1, 1, 0, 2'b00);

      // Load-use on rs, then cleared.
      memrd = 1; wr = 8; rs = 8;
      step("lu_rs", 0, 0, 1, 2'b00);
      memrd = 0;
      step("lu_clear", 1, 1, 0, 2'b00);

      // Load-use on rt only when rt is a source.
      idle(); memrd = 1; wr = 9; rt = 9; rs = 3; use_rt = 1;
      step("lu_rt", 0, 0, 1, 2'b00);
      use_rt = 0;
      step("lu_rt_unused", 1, 1, 0, 2'b00);

      // Register 0 never hazards.
      idle(); memrd = 1; wr = 0; rs = 0;
      step("lu_r0", 1, 1, 0, 2'b00);

      // Jump.
      idle(); jump = 1;
      step("j_id", 1, 0, 0, 2'b01);
      idle();
      step("j_squash", 1, 1, 1, 2'b00);
      step("j_done", 1, 1, 0, 2'b00);

      // beq taken.
`ifdef HAZARD_STATS_EN
      @(negedge clk); cnt_before = stall_count; @(posedge clk); #1;
`endif
      br = 1;
      step("bt_c1", 0, 0, 0, 2'b00);
      br = 0; taken = 1;
      step("bt_c2", 1, 0, 1, 2'b10);
      taken = 0;
      step("bt_c3", 1, 1, 1, 2'b00);
`ifdef HAZARD_STATS_EN
      @(negedge clk);
      check("bt_stall_delta", 32'(stall_count - cnt_before), 32'd3);
      @(posedge clk); #1;
`endif
      step("bt_c4", 1, 1, 0, 2'b00);

      // beq not taken; ID inputs ignored while waiting.
      br = 1;
      step("bn_c1", 0, 0, 0, 2'b00);
      br = 0; memrd = 1; wr = 4; rs = 4; jump = 1;
      step("bn_c2", 1, 1, 1, 2'b00);
      idle();
      step("bn_c3", 1, 1, 0, 2'b00);

      // jr with hazard on rs.
      jr = 1; rs = 31; regwr = 1; wr = 31;
      step("jrh_stall", 0, 0, 1, 2'b00);
      regwr = 0; wr = 0;
      step("jrh_wait", 1, 0, 0, 2'b11);
      idle();
      step("jrh_squash", 1, 1, 1, 2'b00);
      step("jrh_done", 1, 1, 0, 2'b00);

      // jr without hazard.
      jr = 1; rs = 31; regwr = 1; wr = 30;
      step("jr_id", 1, 0, 0, 2'b11);
      idle();
      step("jr_squash", 1, 1, 1, 2'b00);

      // Jump wins over branch; load-use wins over jump.
      jump = 1; br = 1;
      step("jb_id", 1, 0, 0, 2'b01);
      idle();
      step("jb_squash", 1, 1, 1, 2'b00);
      jump = 1; memrd = 1; wr = 5; rs = 5;
      step("lu_over_j", 0, 0, 1, 2'b00);
      memrd = 0;
      step("j_after_lu", 1, 0, 0, 2'b01);
      idle();
      step("j_after_lu_sq", 1, 1, 1, 2'b00);

      // Reset in BRANCH_WAIT returns to NOHAZ.
      br = 1;
      step("br_rst_c1", 0, 0, 0, 2'b00);
      br = 0; taken = 1; rst = 1;
      tick();
      rst = 0;
      step("br_rst_after", 1, 1, 0, 2'b00);
      idle();
      step("br_rst_idle", 1, 1, 0, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
